fm_voice_reg_bank: RTL and testbench
====================================

# fm_voice_reg_bank

Parametrised register bank for the FM synthesizer voice parameters: per-voice carrier, modulator and velocity words plus one control register, all behind a valid/ready write port and a one-cycle-latency read port. Writes land in shadow registers. Shadow values move to the active registers that drive the voice engines either all at once on a commit command or immediately in auto-commit mode. It sits between the host/MIDI decode logic and the voice array, and replaces the fixed 16-voice address constants with a map derived from `NUM_VOICES`.

## Interface
- `NUM_VOICES`, 16: voice count, 1..64.
- `DATA_W`, 32: width of every register.
- `ADDR_W`, 8: address width; must be ≥ clog2(3*NUM_VOICES+1).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write can be accepted.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write data.
- `wr_err`  out  1  one-cycle pulse: an accepted write hit an unmapped address.
- `rd_valid`  in  1  read request; always accepted.
- `rd_addr`  in  ADDR_W  read address.
- `rd_data_valid`  out  1  read response strobe.
- `rd_data`  out  DATA_W  read data; shadow value, or control register.
- `rd_err`  out  1  with `rd_data_valid`: unmapped read address; `rd_data`=0.
- `carrier_out`  out  NUM_VOICES*DATA_W  active carrier words, voice v at [v*DATA_W +: DATA_W].
- `modulator_out`  out  NUM_VOICES*DATA_W  active modulator words, same packing.
- `velocity_out`  out  NUM_VOICES*DATA_W  active velocity words; forced to 0 while MUTE=1.
- `voice_upd`  out  NUM_VOICES  one-cycle pulse per voice whose active registers changed.

## Operation
- Address map, with N=NUM_VOICES:
  - Carrier v at v.
  - Modulator v at N+v.
  - Velocity v at 2N+v.
  - Control at 3N.
  - Any address >3N is unmapped.
- Control register bits:
  - [0] COMMIT: write-1 trigger; self-clearing; always reads 0.
  - [1] AUTO: auto-commit mode.
  - [2] MUTE: forces `velocity_out` to 0.
  - Other bits read 0.
- A write is accepted when `wr_valid` && `wr_ready` on a clock edge.
- Voice-register write:
  - Updates the shadow register.
  - Sets `dirty[v]`.
  - If AUTO=1 at that edge, the active register is updated on the same edge and `dirty[v]` stays clear.
- Unmapped write: no state change; `wr_err` pulses.
- FSM states:
  - IDLE: `wr_ready`=1.
    - Control write with bit0=1 → COMMIT.
    - AUTO/MUTE are stored at that same edge.
  - COMMIT: lasts exactly one cycle; `wr_ready`=0.
    - At its closing edge, active ← shadow for every voice with `dirty[v]`=1.
    - `voice_upd` ← dirty mask; dirty ← 0.
    - Next state is IDLE.
- COMMIT with an all-zero dirty mask still takes one cycle; `voice_upd` stays 0.
- Setting AUTO does not flush pending dirty voices; they wait for an explicit COMMIT.
- Reads:
  - Sample `rd_addr` at the edge where `rd_valid`=1.
  - Return shadow and control contents as they were before any write at that same edge (read-before-write).
  - Reads are allowed in both states.
- MUTE only gates the output; stored velocities are unchanged.
- Reset, any state including mid-COMMIT:
  - All shadow, active, control and dirty registers ← 0; FSM ← IDLE.
  - `wr_ready`=1 once reset is released; all other outputs 0.
  - A pending commit is discarded.

## Timing
- `wr_ready` is decoded from the FSM state only. It never depends combinationally on `wr_valid`.
- Write accepted at edge N, AUTO=1:
  - Active register and output bus change after edge N.
  - `voice_upd[v]` is high for the cycle following edge N.
- Commit write accepted at edge N:
  - The FSM is in COMMIT during cycle N→N+1, with `wr_ready`=0.
  - Outputs change after edge N+1.
  - `voice_upd` is high for cycle N+1→N+2.
  - The next write can be accepted at edge N+2.
- `wr_err` is high for the cycle after the accepting edge.
- Read sampled at edge N: `rd_data_valid`, `rd_data` and `rd_err` are valid for the cycle after edge N. Back-to-back reads give one response per cycle.
- Every output is registered, except:
  - `wr_ready`, decoded from state.
  - `velocity_out` masking, AND with MUTE.

## Test plan
- Reset, then NUM_VOICES=16: write 0x1234 to addr 5 and 0xAB to addr 37 (velocity voice 5).
  - Outputs stay 0.
  - Reading addr 5 returns 0x1234 one cycle later.
  - Write control=0x1 → `wr_ready` low for 1 cycle, `carrier_out`[5]=0x1234, velocity[5]=0xAB, `voice_upd`=0x0020 for 1 cycle.
- Control=0x2 (AUTO), then write 0x55 to addr 16.
  - `modulator_out`[0]=0x55 the cycle after acceptance.
  - `voice_upd`=0x0001 pulse; no COMMIT cycle.
- Write addr 49 and read addr 200.
  - `wr_err` pulses and no register changes.
  - Read gives `rd_err`=1 and `rd_data`=0.
  - Reading addr 48 returns the control value with bit0=0.
- Hold `wr_valid` on through a commit.
  - The second write is stalled exactly one cycle and accepted at N+2.
  - Simultaneous read and write to addr 3 returns the old value.
- Set MUTE with velocity[2]=0x7F.
  - `velocity_out`[2]=0.
  - Clearing MUTE restores 0x7F without a commit.
- Assert `rst_n` low during the COMMIT cycle with voices 1 and 4 dirty.
  - All outputs 0 and no `voice_upd` pulse.
  - `wr_ready`=1 after release.
- Re-run the first scenario with NUM_VOICES=4; the control register is at addr 12.

Source files
------------

// File: rtl/fm_voice_reg_bank.sv
// rtl/fm_voice_reg_bank.sv - FM voice parameter bank: shadow/active register pairs with commit or auto-commit.
module fm_voice_reg_bank #(
  parameter int NUM_VOICES = 16,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         wr_err,
  input  logic                         rd_valid,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_data_valid,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_err,
  output logic [NUM_VOICES*DATA_W-1:0] carrier_out,
  output logic [NUM_VOICES*DATA_W-1:0] modulator_out,
  output logic [NUM_VOICES*DATA_W-1:0] velocity_out,
  output logic [NUM_VOICES-1:0]        voice_upd
);

  typedef enum logic {S_IDLE, S_COMMIT} state_t;

  localparam logic [ADDR_W-1:0] L_CTRL_ADDR = ADDR_W'(3 * NUM_VOICES);

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [DATA_W-1:0]              r_sh_car [NUM_VOICES];
  logic [DATA_W-1:0]              r_sh_mod [NUM_VOICES];
  logic [DATA_W-1:0]              r_sh_vel [NUM_VOICES];
  logic [NUM_VOICES*DATA_W-1:0]   r_act_car;
  logic [NUM_VOICES*DATA_W-1:0]   r_act_mod;
  logic [NUM_VOICES*DATA_W-1:0]   r_act_vel;
  logic [NUM_VOICES-1:0]          r_dirty;
  logic [NUM_VOICES-1:0]          r_voice_upd;
  logic                           r_auto;
  logic                           r_mute;
  logic                           r_wr_err;
  logic                           r_rd_valid;
  logic [DATA_W-1:0]              r_rd_data;
  logic                           r_rd_err;
  logic                           w_wr_acc;
  logic                           w_ctrl_wr;
  logic [DATA_W-1:0]              w_rd_data;

  assign wr_ready      = (r_state == S_IDLE);
  assign w_wr_acc      = wr_valid && wr_ready;
  assign w_ctrl_wr     = w_wr_acc && (wr_addr == L_CTRL_ADDR);
  assign wr_err        = r_wr_err;
  assign rd_data_valid = r_rd_valid;
  assign rd_data       = r_rd_data;
  assign rd_err        = r_rd_err;
  assign carrier_out   = r_act_car;
  assign modulator_out = r_act_mod;
  assign velocity_out  = r_mute ? '0 : r_act_vel;
  assign voice_upd     = r_voice_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_ctrl_wr && wr_data[0]) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Read mux sees pre-edge shadow contents, giving read-before-write for free.
  always_comb begin
    w_rd_data = '0;
    if (rd_addr == L_CTRL_ADDR) w_rd_data = DATA_W'({r_mute, r_auto, 1'b0});
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rd_addr == ADDR_W'(v))                  w_rd_data = r_sh_car[v];
      if (rd_addr == ADDR_W'(NUM_VOICES + v))     w_rd_data = r_sh_mod[v];
      if (rd_addr == ADDR_W'(2 * NUM_VOICES + v)) w_rd_data = r_sh_vel[v];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_sh_car[v] <= '0;
        r_sh_mod[v] <= '0;
        r_sh_vel[v] <= '0;
      end
      r_act_car   <= '0;
      r_act_mod   <= '0;
      r_act_vel   <= '0;
      r_dirty     <= '0;
      r_voice_upd <= '0;
      r_auto      <= 1'b0;
      r_mute      <= 1'b0;
      r_wr_err    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_err    <= 1'b0;
    end else begin
      r_voice_upd <= '0;
      r_wr_err    <= w_wr_acc && (wr_addr > L_CTRL_ADDR);
      r_rd_valid  <= rd_valid;
      r_rd_data   <= rd_valid ? w_rd_data : '0;
      r_rd_err    <= rd_valid && (rd_addr > L_CTRL_ADDR);
      if (w_ctrl_wr) begin
        r_auto <= wr_data[1];
        r_mute <= wr_data[2];
      end
      // wr_ready is low in COMMIT, so no voice write can collide with the transfer.
      if (r_state == S_COMMIT) begin
        r_voice_upd <= r_dirty;
        r_dirty     <= '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (r_dirty[v]) begin
            r_act_car[v*DATA_W +: DATA_W] <= r_sh_car[v];
            r_act_mod[v*DATA_W +: DATA_W] <= r_sh_mod[v];
            r_act_vel[v*DATA_W +: DATA_W] <= r_sh_vel[v];
          end
        end
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (w_wr_acc && wr_addr == ADDR_W'(v)) begin
          r_sh_car[v] <= wr_data;
          if (r_auto) begin
            r_act_car[v*DATA_W +: DATA_W] <= wr_data;
            r_voice_upd[v]                <= 1'b1;
          end else begin
            r_dirty[v] <= 1'b1;
          end
        end
        if (w_wr_acc && wr_addr == ADDR_W'(NUM_VOICES + v)) begin
          r_sh_mod[v] <= wr_data;
          if (r_auto) begin
            r_act_mod[v*DATA_W +: DATA_W] <= wr_data;
            r_voice_upd[v]                <= 1'b1;
          end else begin
            r_dirty[v] <= 1'b1;
          end
        end
        if (w_wr_acc && wr_addr == ADDR_W'(2 * NUM_VOICES + v)) begin
          r_sh_vel[v] <= wr_data;
          if (r_auto) begin
            r_act_vel[v*DATA_W +: DATA_W] <= wr_data;
            r_voice_upd[v]                <= 1'b1;
          end else begin
            r_dirty[v] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fm_voice_reg_bank.sv
// tb/tb_fm_voice_reg_bank.sv - directed table-driven bench for fm_voice_reg_bank (16- and 4-voice builds).
module tb_fm_voice_reg_bank;

  logic         clk;
  logic         rst_n;
  logic         wr_valid, wr_ready, wr_err;
  logic [7:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         rd_valid, rd_data_valid, rd_err;
  logic [7:0]   rd_addr;
  logic [31:0]  rd_data;
  logic [511:0] carrier_out, modulator_out, velocity_out;
  logic [15:0]  voice_upd;

  logic         b_wr_valid, b_wr_ready, b_wr_err;
  logic [7:0]   b_wr_addr;
  logic [31:0]  b_wr_data;
  logic         b_rd_valid, b_rd_data_valid, b_rd_err;
  logic [7:0]   b_rd_addr;
  logic [31:0]  b_rd_data;
  logic [127:0] b_carrier_out, b_modulator_out, b_velocity_out;
  logic [3:0]   b_voice_upd;

  int n_vec = 0;
  int n_err = 0;

  fm_voice_reg_bank #(.NUM_VOICES(16), .DATA_W(32), .ADDR_W(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_err(rd_err),
    .carrier_out(carrier_out), .modulator_out(modulator_out), .velocity_out(velocity_out),
    .voice_upd(voice_upd)
  );

  fm_voice_reg_bank #(.NUM_VOICES(4), .DATA_W(32), .ADDR_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_err(b_wr_err),
    .rd_valid(b_rd_valid), .rd_addr(b_rd_addr), .rd_data_valid(b_rd_data_valid), .rd_data(b_rd_data), .rd_err(b_rd_err),
    .carrier_out(b_carrier_out), .modulator_out(b_modulator_out), .velocity_out(b_velocity_out),
    .voice_upd(b_voice_upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock: inputs held over the edge, ready checked before it, outputs after it.
  typedef struct {
    string       name;
    logic        wv;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic        rv;
    logic [7:0]  ra;
    logic        rdy;
    logic        werr;
    logic        rdv;
    logic [31:0] rd;
    logic        rerr;
    logic [15:0] upd;
    int          bus;
    int          vi;
    logic [31:0] bv;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(string n, logic wv, logic [7:0] wa, logic [31:0] wd,
                              logic rv, logic [7:0] ra, logic rdy, logic werr, logic rdv,
                              logic [31:0] rd, logic rerr, logic [15:0] upd,
                              int bus, int vi, logic [31:0] bv);
    vec_t t;
    t.name = n; t.wv = wv; t.wa = wa; t.wd = wd; t.rv = rv; t.ra = ra;
    t.rdy = rdy; t.werr = werr; t.rdv = rdv; t.rd = rd; t.rerr = rerr;
    t.upd = upd; t.bus = bus; t.vi = vi; t.bv = bv;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bus_word(int b, int vi);
    case (b)
      1:       return carrier_out[vi*32 +: 32];
      2:       return modulator_out[vi*32 +: 32];
      default: return velocity_out[vi*32 +: 32];
    endcase
  endfunction

  task automatic apply(input vec_t t);
    @(negedge clk);
    wr_valid = t.wv; wr_addr = t.wa; wr_data = t.wd;
    rd_valid = t.rv; rd_addr = t.ra;
    chk({t.name, ".wr_ready"}, {31'b0, wr_ready}, {31'b0, t.rdy});
    @(posedge clk);
    #1;
    chk({t.name, ".wr_err"}, {31'b0, wr_err}, {31'b0, t.werr});
    chk({t.name, ".rd_data_valid"}, {31'b0, rd_data_valid}, {31'b0, t.rdv});
    if (t.rdv) begin
      chk({t.name, ".rd_data"}, rd_data, t.rd);
      chk({t.name, ".rd_err"}, {31'b0, rd_err}, {31'b0, t.rerr});
    end
    chk({t.name, ".voice_upd"}, {16'b0, voice_upd}, {16'b0, t.upd});
    if (t.bus != 0) chk({t.name, ".bus"}, bus_word(t.bus, t.vi), t.bv);
  endtask

  task automatic b_step(input logic wv, input logic [7:0] wa, input logic [31:0] wd,
                        input logic rv, input logic [7:0] ra);
    @(negedge clk);
    b_wr_valid = wv; b_wr_addr = wa; b_wr_data = wd; b_rd_valid = rv; b_rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_valid = 1'b0; rd_addr = '0;
    b_wr_valid = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_valid = 1'b0; b_rd_addr = '0;

    //             name            wv wa     wd           rv ra    rdy werr rdv rd        rerr upd       bus vi bv
    tv.push_back(mk("wr_car5",      1, 8'd5,  32'h1234,    0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 1, 5, 32'h0));
    tv.push_back(mk("wr_vel5",      1, 8'd37, 32'hAB,      0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 3, 5, 32'h0));
    tv.push_back(mk("rd_car5",      0, 8'd0,  32'h0,       1, 8'd5, 1, 0, 1, 32'h1234, 0, 16'h0000, 1, 5, 32'h0));
    tv.push_back(mk("commit1",      1, 8'd48, 32'h1,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 1, 5, 32'h0));
    tv.push_back(mk("commit1_busy", 0, 8'd0,  32'h0,       0, 8'd0, 0, 0, 0, 32'h0,    0, 16'h0020, 1, 5, 32'h1234));
    tv.push_back(mk("commit1_done", 0, 8'd0,  32'h0,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 3, 5, 32'hAB));
    tv.push_back(mk("auto_on",      1, 8'd48, 32'h2,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 0, 0, 32'h0));
    tv.push_back(mk("auto_mod0",    1, 8'd16, 32'h55,      0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0001, 2, 0, 32'h55));
    tv.push_back(mk("auto_idle",    0, 8'd0,  32'h0,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 2, 0, 32'h55));
    tv.push_back(mk("unmapped",     1, 8'd49, 32'hDEAD,    1, 8'd200, 1, 1, 1, 32'h0,  1, 16'h0000, 2, 0, 32'h55));
    tv.push_back(mk("rd_ctrl",      0, 8'd0,  32'h0,       1, 8'd48, 1, 0, 1, 32'h2,   0, 16'h0000, 1, 5, 32'h1234));
    tv.push_back(mk("rd_49",        0, 8'd0,  32'h0,       1, 8'd49, 1, 0, 1, 32'h0,   1, 16'h0000, 0, 0, 32'h0));
    tv.push_back(mk("auto_off",     1, 8'd48, 32'h0,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 0, 0, 32'h0));
    tv.push_back(mk("wr_car3",      1, 8'd3,  32'h33,      0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 1, 3, 32'h0));
    tv.push_back(mk("commit2",      1, 8'd48, 32'h1,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 1, 3, 32'h0));
    tv.push_back(mk("stall",        1, 8'd3,  32'h77,      1, 8'd3, 0, 0, 1, 32'h33,   0, 16'h0008, 1, 3, 32'h33));
    tv.push_back(mk("accept",       1, 8'd3,  32'h77,      1, 8'd3, 1, 0, 1, 32'h33,   0, 16'h0000, 1, 3, 32'h33));
    tv.push_back(mk("rd_car3",      0, 8'd0,  32'h0,       1, 8'd3, 1, 0, 1, 32'h77,   0, 16'h0000, 1, 3, 32'h33));
    tv.push_back(mk("wr_vel2",      1, 8'd34, 32'h7F,      0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 3, 2, 32'h0));
    tv.push_back(mk("commit3",      1, 8'd48, 32'h1,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 3, 2, 32'h0));
    tv.push_back(mk("commit3_busy", 0, 8'd0,  32'h0,       0, 8'd0, 0, 0, 0, 32'h0,    0, 16'h000C, 3, 2, 32'h7F));
    tv.push_back(mk("commit3_done", 0, 8'd0,  32'h0,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 1, 3, 32'h77));
    tv.push_back(mk("mute_on",      1, 8'd48, 32'h4,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 3, 2, 32'h0));
    tv.push_back(mk("rd_vel2",      0, 8'd0,  32'h0,       1, 8'd34, 1, 0, 1, 32'h7F,  0, 16'h0000, 3, 2, 32'h0));
    tv.push_back(mk("rd_ctrl_mute", 0, 8'd0,  32'h0,       1, 8'd48, 1, 0, 1, 32'h4,   0, 16'h0000, 3, 5, 32'h0));
    tv.push_back(mk("mute_off",     1, 8'd48, 32'h0,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 3, 2, 32'h7F));
    tv.push_back(mk("commit_empty", 1, 8'd48, 32'h1,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 0, 0, 32'h0));
    tv.push_back(mk("empty_busy",   0, 8'd0,  32'h0,       0, 8'd0, 0, 0, 0, 32'h0,    0, 16'h0000, 0, 0, 32'h0));
    tv.push_back(mk("empty_done",   0, 8'd0,  32'h0,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 0, 0, 32'h0));
    tv.push_back(mk("wr_car6",      1, 8'd6,  32'h66,      0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 1, 6, 32'h0));
    tv.push_back(mk("auto_on2",     1, 8'd48, 32'h2,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 1, 6, 32'h0));
    tv.push_back(mk("auto_noflush", 0, 8'd0,  32'h0,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 1, 6, 32'h0));
    tv.push_back(mk("auto_off2",    1, 8'd48, 32'h0,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 1, 6, 32'h0));
    tv.push_back(mk("wr_car1",      1, 8'd1,  32'h11,      0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 1, 1, 32'h0));
    tv.push_back(mk("wr_car4",      1, 8'd4,  32'h44,      0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 1, 4, 32'h0));
    tv.push_back(mk("commit_rst",   1, 8'd48, 32'h1,       0, 8'd0, 1, 0, 0, 32'h0,    0, 16'h0000, 1, 1, 32'h0));

    repeat (3) @(posedge clk);
    #1;
    chk("reset.wr_err", {31'b0, wr_err}, 32'h0);
    chk("reset.rd_data_valid", {31'b0, rd_data_valid}, 32'h0);
    chk("reset.voice_upd", {16'b0, voice_upd}, 32'h0);
    chk("reset.buses", {31'b0, |{carrier_out, modulator_out, velocity_out}}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset.wr_ready", {31'b0, wr_ready}, 32'h1);

    for (int i = 0; i < tv.size(); i++) apply(tv[i]);

    // Reset lands mid-COMMIT with voices 1 and 4 dirty: the pending transfer must vanish.
    @(negedge clk);
    wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.buses", {31'b0, |{carrier_out, modulator_out, velocity_out}}, 32'h0);
    chk("rst_mid.voice_upd", {16'b0, voice_upd}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid.wr_ready", {31'b0, wr_ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("rst_mid.voice_upd_after", {16'b0, voice_upd}, 32'h0);
    chk("rst_mid.car1", carrier_out[1*32 +: 32], 32'h0);
    chk("rst_mid.car4", carrier_out[4*32 +: 32], 32'h0);
    apply(mk("rst_rd_car1", 0, 8'd0, 32'h0, 1, 8'd1, 1, 0, 1, 32'h0, 0, 16'h0000, 1, 1, 32'h0));
    rd_valid = 1'b0;

    // Four-voice build: velocity voice 1 at 9, control at 12.
    b_step(1, 8'd1, 32'h1234, 0, 8'd0);
    chk("n4.car1_pre", b_carrier_out[1*32 +: 32], 32'h0);
    b_step(1, 8'd9, 32'hAB, 0, 8'd0);
    b_step(0, 8'd0, 32'h0, 1, 8'd1);
    chk("n4.rd_valid", {31'b0, b_rd_data_valid}, 32'h1);
    chk("n4.rd_car1", b_rd_data, 32'h1234);
    b_step(1, 8'd12, 32'h1, 0, 8'd0);
    chk("n4.wr_ready_commit", {31'b0, b_wr_ready}, 32'h0);
    chk("n4.vel1_pre", b_velocity_out[1*32 +: 32], 32'h0);
    b_step(0, 8'd0, 32'h0, 0, 8'd0);
    chk("n4.voice_upd", {28'b0, b_voice_upd}, 32'h2);
    chk("n4.car1", b_carrier_out[1*32 +: 32], 32'h1234);
    chk("n4.vel1", b_velocity_out[1*32 +: 32], 32'hAB);
    chk("n4.wr_ready_idle", {31'b0, b_wr_ready}, 32'h1);
    b_step(0, 8'd0, 32'h0, 1, 8'd12);
    chk("n4.upd_clear", {28'b0, b_voice_upd}, 32'h0);
    chk("n4.rd_ctrl", b_rd_data, 32'h0);
    chk("n4.rd_ctrl_err", {31'b0, b_rd_err}, 32'h0);
    b_step(1, 8'd13, 32'h5, 1, 8'd13);
    chk("n4.wr_err", {31'b0, b_wr_err}, 32'h1);
    chk("n4.rd_err", {31'b0, b_rd_err}, 32'h1);
    chk("n4.rd_unmapped_data", b_rd_data, 32'h0);
    b_step(0, 8'd0, 32'h0, 0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
